// File: rtl/hex_operand_loader_if.sv
// rtl/hex_operand_loader_if.sv - operand-entry bus between loader and comparator side
interface hex_operand_loader_if;
  logic [3:0] nibble_in;
  logic       load_btn;
  logic       clr;
  logic [3:0] a_hex;
  logic [3:0] b_hex;
  logic       a_loaded;
  logic       operands_valid;
  logic       cmp_strobe;
  logic       load_ack;

  // loader side: takes raw switches/button, drives the captured operands
  modport master (
    input  nibble_in, load_btn, clr,
    output a_hex, b_hex, a_loaded, operands_valid, cmp_strobe, load_ack
  );

  // user/comparator side: drives the raw inputs, consumes the operands
  modport slave (
    output nibble_in, load_btn, clr,
    input  a_hex, b_hex, a_loaded, operands_valid, cmp_strobe, load_ack
  );
endinterface

// File: rtl/hex_operand_loader.sv
// rtl/hex_operand_loader.sv - debounced push-button loader for comparator operands A/B
module hex_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_operand_loader_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, HAVE_A, FULL} state_t;

  logic [1:0]    btn_sync;
  logic [3:0]    nib_q1;
  logic [3:0]    nib_q2;
  logic          s_btn;
  logic [3:0]    s_nib;
  logic          deb_level;
  logic [CW-1:0] cnt;
  logic          evt;

  state_t     state;
  logic [3:0] a_hex_q;
  logic [3:0] b_hex_q;
  logic       a_loaded_q;
  logic       valid_q;
  logic       strobe_q;
  logic       ack_q;

  assign s_btn = btn_sync[1];
  assign s_nib = nib_q2;

  // Two-flop synchronizers for the asynchronous button and switch inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync <= 2'b00;
      nib_q1   <= 4'h0;
      nib_q2   <= 4'h0;
    end else begin
      btn_sync <= {btn_sync[0], bus.load_btn};
      nib_q1   <= bus.nibble_in;
      nib_q2   <= nib_q1;
    end
  end

  // Debouncer: accept a new level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level <= 1'b0;
      cnt       <= '0;
    end else if (s_btn == deb_level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      deb_level <= s_btn;
      cnt       <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Debounced rising edge only; releases never generate a load
  assign evt = s_btn & ~deb_level & (cnt == CNT_MAX);

  // Operand capture FSM; clr abandons the entry and swallows a coincident event
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      a_hex_q    <= 4'h0;
      b_hex_q    <= 4'h0;
      a_loaded_q <= 1'b0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      if (bus.clr) begin
        state      <= EMPTY;
        a_hex_q    <= 4'h0;
        b_hex_q    <= 4'h0;
        a_loaded_q <= 1'b0;
        valid_q    <= 1'b0;
      end else if (evt) begin
        ack_q <= 1'b1;
        case (state)
          EMPTY: begin
            a_hex_q    <= s_nib;
            a_loaded_q <= 1'b1;
            state      <= HAVE_A;
          end
          HAVE_A: begin
            b_hex_q  <= s_nib;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
            state    <= FULL;
          end
          FULL: begin
            // B is retained so the comparator input does not glitch
            a_hex_q <= s_nib;
            valid_q <= 1'b0;
            state   <= HAVE_A;
          end
          default: begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.a_hex          = a_hex_q;
  assign bus.b_hex          = b_hex_q;
  assign bus.a_loaded       = a_loaded_q;
  assign bus.operands_valid = valid_q;
  assign bus.cmp_strobe     = strobe_q;
  assign bus.load_ack       = ack_q;

endmodule

// File: tb/tb_hex_operand_loader.sv
// tb/tb_hex_operand_loader.sv - scoreboard bench for hex_operand_loader
module tb_hex_operand_loader;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  hex_operand_loader_if bus();

  hex_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
    logic       al;
    logic       vld;
    logic       stb;
  } exp_t;

  exp_t q[$];

  // Reference model: which operand the next press fills and the current values
  int         m_count;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic       m_al;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_count = 0;
    m_a = 4'h0;
    m_b = 4'h0;
    m_al = 1'b0;
  endtask

  // A completed press: fills A when nothing or a full pair is held, else fills B
  task automatic model_press(input logic [3:0] v, input int cap_cyc);
    exp_t e;
    if (m_count == 1) begin
      m_b = v;
      m_count = 2;
    end else begin
      m_a = v;
      m_count = 1;
    end
    m_al = 1'b1;
    e.cyc = cap_cyc;
    e.a   = m_a;
    e.b   = m_b;
    e.al  = m_al;
    e.vld = (m_count == 2);
    e.stb = (m_count == 2);
    q.push_back(e);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_a_hex"}, int'(bus.a_hex), 0);
    chk({tag, "_b_hex"}, int'(bus.b_hex), 0);
    chk({tag, "_a_loaded"}, int'(bus.a_loaded), 0);
    chk({tag, "_valid"}, int'(bus.operands_valid), 0);
  endtask

  task automatic press(input logic [3:0] v, input bit bounce);
    int k;
    bus.nibble_in = v;
    idle(3);
    if (bounce) begin
      repeat ($urandom_range(1, 3)) begin
        bus.load_btn = 1'b1;
        idle($urandom_range(1, D - 1));
        bus.load_btn = 1'b0;
        idle($urandom_range(1, 2));
      end
    end
    bus.load_btn = 1'b1;
    k = cyc + 1;
    model_press(v, k + 1 + D);
    idle(D + 4 + $urandom_range(0, 5));
    bus.load_btn = 1'b0;
    idle(D + 4 + $urandom_range(0, 3));
  endtask

  // Monitor: every ack must match the oldest expected capture
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.load_ack || bus.cmp_strobe)) begin
      if (!bus.load_ack) begin
        chk("stray_strobe", 1, 0);
      end else if (q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("a_hex", int'(bus.a_hex), int'(e.a));
        chk("b_hex", int'(bus.b_hex), int'(e.b));
        chk("a_loaded", int'(bus.a_loaded), int'(e.al));
        chk("operands_valid", int'(bus.operands_valid), int'(e.vld));
        chk("cmp_strobe", int'(bus.cmp_strobe), int'(e.stb));
      end
    end
  end

  initial begin
    int k;
    logic [3:0] v;
    bus.nibble_in = 4'h0;
    bus.load_btn  = 1'b0;
    bus.clr       = 1'b0;
    model_clear();
    idle(3);
    check_cleared("reset");
    chk("reset_ack", int'(bus.load_ack), 0);
    chk("reset_strobe", int'(bus.cmp_strobe), 0);
    rst = 1'b0;

    // A then B, then bounce that must not load
    press(4'h9, 1'b0);
    press(4'h3, 1'b0);
    chk("full_gt", int'(bus.a_hex > bus.b_hex), 1);
    bus.load_btn = 1'b1; idle(2);
    bus.load_btn = 1'b0; idle(1);
    bus.load_btn = 1'b1; idle(2);
    bus.load_btn = 1'b0; idle(D + 4);

    // Reload A from FULL, then B equal
    press(4'hC, 1'b0);
    chk("reload_b_kept", int'(bus.b_hex), 3);
    press(4'hC, 1'b0);
    chk("full_eq", int'(bus.a_hex == bus.b_hex), 1);

    // clr on the exact B-capture edge
    press(4'h5, 1'b0);
    bus.nibble_in = 4'h7;
    idle(3);
    bus.load_btn = 1'b1;
    idle(D + 1);
    bus.clr = 1'b1;
    idle(1);
    bus.clr = 1'b0;
    model_clear();
    check_cleared("clr_on_evt");
    idle(D);
    bus.load_btn = 1'b0;
    idle(D + 4);
    press(4'h2, 1'b0);

    // Reset while the button is held and cnt is 2
    bus.nibble_in = 4'hA;
    idle(3);
    bus.load_btn = 1'b1;
    k = cyc + 1;
    idle(4);
    rst = 1'b1;
    idle(1);
    model_clear();
    check_cleared("mid_reset");
    rst = 1'b0;
    model_press(4'hA, k + 4 + 2 + D);
    idle(D + 6);
    bus.load_btn = 1'b0;
    idle(D + 4);

    // Randomized presses with bounces and occasional idle clears
    for (int i = 0; i < 24; i++) begin
      v = 4'($urandom_range(0, 15));
      press(v, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        model_clear();
        check_cleared("rand_clr");
      end
    end

    idle(10);
    chk("pending_captures", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hex_operand_loader.md
# hex_operand_loader

Operand-entry stage that feeds the 4-bit magnitude comparator. Takes a quasi-static 4-bit switch value and a raw, bouncy load push-button, synchronizes and debounces the button, and on each clean press captures the nibble alternately as operand A then operand B. Presents stable `a_hex`/`b_hex` to the comparator, flags when a complete pair is present, and pulses a strobe when the comparator result first reflects a fresh pair.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized-stable cycles required to accept a button level change; legal range 2..65535; counter width is `$clog2(DEBOUNCE_CYCLES)`.

- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high; overrides every other input.
- `nibble_in` in 4: raw switch value, asynchronous to `clk`.
- `load_btn` in 1: raw push-button, asynchronous and bouncy, active-high.
- `clr` in 1: synchronous, already-clean, active-high level; abandons the current entry.
- `a_hex` out 4: captured operand A, to comparator `a_hex`.
- `b_hex` out 4: captured operand B, to comparator `b_hex`.
- `a_loaded` out 1: A holds a value captured since the last reset or clear.
- `operands_valid` out 1: high only in state FULL; comparator outputs are meaningful.
- `cmp_strobe` out 1: one-cycle pulse in the cycle after B is captured.
- `load_ack` out 1: one-cycle pulse in the cycle after any capture (A or B).

## Operation

- Synchronizers: `load_btn` and each `nibble_in` bit pass through two flops; `s_btn` and `s_nib` are the second-stage values.
- Debouncer: registered `deb_level` and counter `cnt`.
  - If `s_btn == deb_level`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `deb_level <= s_btn`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- Load event `evt`, combinational: `s_btn & ~deb_level & (cnt == DEBOUNCE_CYCLES-1)`, i.e. the debounced rising edge. Debounced falling edges produce nothing. A held button produces exactly one event.
- FSM, priority `rst` > `clr` > `evt`:
  - EMPTY: on `evt`, `a_hex <= s_nib`, `a_loaded <= 1`, go to HAVE_A.
  - HAVE_A: on `evt`, `b_hex <= s_nib`, go to FULL, `cmp_strobe <= 1`.
  - FULL: on `evt`, `a_hex <= s_nib`, go to HAVE_A. `b_hex` keeps its old value, but `operands_valid` drops.
  - Every capture sets `load_ack <= 1` for one cycle. Otherwise `load_ack` and `cmp_strobe` are 0.
- `clr`: go to EMPTY; `a_hex`, `b_hex`, `a_loaded`, `cmp_strobe` and `load_ack` become 0. Synchronizer and debouncer are unaffected, so a press in progress completes and, if its event coincides with `clr`, the event is dropped.
- `a_hex`/`b_hex` change only on a capture edge, on `clr` or on `rst`, so the downstream comparator sees glitch-free operands.

## Timing

- Reset values:
  - `a_hex` = 0, `b_hex` = 0, `a_loaded` = 0, `operands_valid` = 0, `cmp_strobe` = 0, `load_ack` = 0.
  - State EMPTY; both synchronizer stages 0; `deb_level` = 0; `cnt` = 0.
- Reset mid-debounce discards the partial count. A button still high after reset is accepted as a new press after the full latency.
- Press latency: if edge k is the first edge that samples `load_btn` high, with the button held clean thereafter:
  - `s_btn` rises at edge k+1.
  - Capture happens at edge k+1+`DEBOUNCE_CYCLES`.
  - `load_ack` (and `cmp_strobe` for B) is high for the following cycle only.
- Any `s_btn` bounce back to `deb_level` before the count completes resets `cnt`; the count restarts on the next difference.
- `nibble_in` must be stable for at least 3 cycles before the capture edge. The captured value is `s_nib` at that edge.
- Release latency matches press latency. A new press is recognized only after a debounced release.
- Throughput: at most one capture per 2×`DEBOUNCE_CYCLES`+2 cycles.

## Test plan

- Reset with `DEBOUNCE_CYCLES`=4 and `load_btn` held 0: all outputs 0, state EMPTY. Set `nibble_in`=0x9 and raise the button so edge 10 first samples it high -> `a_hex`=0x9 and `a_loaded`=1 at edge 15; `load_ack` high in cycle 15–16 only; `operands_valid`=0.
- Release the button, set `nibble_in`=0x3, then press cleanly -> `b_hex`=0x3, `operands_valid`=1, `cmp_strobe` and `load_ack` are single-cycle pulses. The comparator then reports gt=1, eq=0, lt=0.
- Bounce: `load_btn` toggles high 2 cycles, low 1, high 2, low -> no capture, `load_ack` never asserts, `cnt` returns to 0.
- From FULL (A=0x9, B=0x3), press with `nibble_in`=0xC -> `a_hex`=0xC, `b_hex` remains 0x3, `operands_valid`=0, state HAVE_A. Press with 0xC again -> FULL, comparator eq=1.
- Assert `clr` on the exact edge of a B capture event -> state EMPTY, `a_hex`=`b_hex`=0, no `cmp_strobe`. The next press loads A.
- Assert `rst` mid-debounce (`cnt`=2) while the button is held -> outputs at reset values. The held button then captures A exactly 1+`DEBOUNCE_CYCLES` edges after the synchronizer refills.
